// File: rtl/escalonador_tx.sv
// Round-robin scheduler for two requesters that sends each (command, data) frame
// as two bytes through a UART transmitter, with a per-byte completion timeout.
module escalonador_tx #(
  parameter int TIMEOUT_CICLOS = 2000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       req0,
  input  logic       req1,
  input  logic [7:0] cmd0,
  input  logic [7:0] dado0,
  input  logic [7:0] cmd1,
  input  logic [7:0] dado1,
  output logic       ack0,
  output logic       ack1,
  output logic       fim0,
  output logic       fim1,
  output logic       tx_inicia,
  output logic [7:0] tx_byte,
  input  logic       tx_ativo,
  input  logic       tx_concluido,
  output logic       ocupado,
  output logic       erro_timeout,
  output logic [2:0] o_estado
);

  typedef enum logic [2:0] {
    OCIOSO    = 3'd0,
    INICIA_B0 = 3'd1,
    ESPERA_B0 = 3'd2,
    INICIA_B1 = 3'd3,
    ESPERA_B1 = 3'd4
  } estado_t;

  localparam logic [15:0] LIMITE = 16'(TIMEOUT_CICLOS - 1);

  estado_t     r_estado;
  estado_t     w_prox;
  logic        r_ultimo;
  logic [7:0]  r_dado;
  logic [7:0]  r_tx_byte;
  logic        r_ack0;
  logic        r_ack1;
  logic        r_fim0;
  logic        r_fim1;
  logic        r_erro;
  logic        r_concl_ant;
  logic [15:0] r_cont;

  logic w_ativo;
  logic w_espera;
  logic w_subida;
  logic w_expira;
  logic w_concede;
  logic w_venc;
  logic w_fim;
  logic w_estouro;

  // Handshakes: reqN is held until ackN pulses (frame captured on that edge);
  // tx_inicia acts as valid and tx_ativo sampled high acts as ready, the byte
  // is taken on the edge where both are seen, and tx_inicia drops right after.
  assign w_ativo   = (r_estado != OCIOSO);
  assign w_espera  = (r_estado == ESPERA_B0) || (r_estado == ESPERA_B1);
  assign w_subida  = tx_concluido & ~r_concl_ant;
  assign w_expira  = w_ativo && (r_cont >= LIMITE);
  assign w_concede = (r_estado == OCIOSO) && (req0 || req1);
  assign w_venc    = (req0 && req1) ? ~r_ultimo : req1;
  assign w_fim     = (r_estado == ESPERA_B1) && w_subida;
  assign w_estouro = w_expira && !(w_espera && w_subida);

  always_ff @(posedge clock) begin
    if (reset) r_estado <= OCIOSO;
    else       r_estado <= w_prox;
  end

  always_comb begin
    w_prox = r_estado;
    case (r_estado)
      OCIOSO:    if (w_concede) w_prox = INICIA_B0;
      INICIA_B0: if (w_expira) w_prox = OCIOSO;
                 else if (tx_ativo) w_prox = ESPERA_B0;
      ESPERA_B0: if (w_subida) w_prox = INICIA_B1;
                 else if (w_expira) w_prox = OCIOSO;
      INICIA_B1: if (w_expira) w_prox = OCIOSO;
                 else if (tx_ativo) w_prox = ESPERA_B1;
      ESPERA_B1: if (w_subida || w_expira) w_prox = OCIOSO;
      default:   w_prox = OCIOSO;
    endcase
  end

  always_comb begin
    tx_inicia = (r_estado == INICIA_B0) || (r_estado == INICIA_B1);
    ocupado   = w_ativo;
  end

  // r_ultimo doubles as the owner of the frame in flight, since it takes the winner at grant.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_ultimo    <= 1'b1;
      r_dado      <= 8'h00;
      r_tx_byte   <= 8'h00;
      r_ack0      <= 1'b0;
      r_ack1      <= 1'b0;
      r_fim0      <= 1'b0;
      r_fim1      <= 1'b0;
      r_erro      <= 1'b0;
      r_concl_ant <= 1'b0;
      r_cont      <= 16'd0;
    end else begin
      r_concl_ant <= tx_concluido;
      r_ack0      <= 1'b0;
      r_ack1      <= 1'b0;
      r_fim0      <= 1'b0;
      r_fim1      <= 1'b0;
      if (w_concede) begin
        r_ultimo  <= w_venc;
        r_dado    <= w_venc ? dado1 : dado0;
        r_tx_byte <= w_venc ? cmd1 : cmd0;
        r_ack0    <= ~w_venc;
        r_ack1    <= w_venc;
      end
      if ((r_estado == ESPERA_B0) && w_subida) r_tx_byte <= r_dado;
      if (w_fim) begin
        r_fim0 <= ~r_ultimo;
        r_fim1 <= r_ultimo;
      end
      if (w_estouro) r_erro <= 1'b1;
      if (w_concede || ((r_estado == ESPERA_B0) && w_subida)) r_cont <= 16'd0;
      else if (w_ativo && (r_cont != 16'hFFFF)) r_cont <= r_cont + 16'd1;
    end
  end

  assign ack0         = r_ack0;
  assign ack1         = r_ack1;
  assign fim0         = r_fim0;
  assign fim1         = r_fim1;
  assign tx_byte      = r_tx_byte;
  assign erro_timeout = r_erro;
  assign o_estado     = r_estado;

endmodule

// File: tb/tb_escalonador_tx.sv
// Bench for escalonador_tx: a behavioural UART transmitter on the main instance and a
// stuck transmitter on a second instance (TIMEOUT_CICLOS=50) for the timeout scenario.
module tb_escalonador_tx;

  logic       clock = 1'b0;
  logic       reset;
  logic       req0, req1;
  logic [7:0] cmd0, dado0, cmd1, dado1;
  logic       ack0, ack1, fim0, fim1, tx_inicia;
  logic [7:0] tx_byte;
  logic       tx_ativo, tx_concluido, ocupado, erro_timeout;
  logic [2:0] estado;

  logic       b_req0, b_req1;
  logic [7:0] b_cmd0, b_dado0, b_cmd1, b_dado1;
  logic       b_ack0, b_ack1, b_fim0, b_fim1, b_tx_inicia;
  logic [7:0] b_tx_byte;
  logic       b_tx_ativo, b_tx_concluido, b_ocupado, b_erro;
  logic [2:0] b_estado;

  int n_chk = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];

  int   m_cpb  = 4;
  int   m_len  = 1;
  int   m_cnt  = 0;
  int   m_done = 0;
  logic m_busy = 1'b0;
  int   fim0_cnt = 0, fim1_cnt = 0, b_fim_cnt = 0;

  always #5 clock = ~clock;

  escalonador_tx u_dut (
    .clock(clock), .reset(reset), .req0(req0), .req1(req1),
    .cmd0(cmd0), .dado0(dado0), .cmd1(cmd1), .dado1(dado1),
    .ack0(ack0), .ack1(ack1), .fim0(fim0), .fim1(fim1),
    .tx_inicia(tx_inicia), .tx_byte(tx_byte), .tx_ativo(tx_ativo),
    .tx_concluido(tx_concluido), .ocupado(ocupado),
    .erro_timeout(erro_timeout), .o_estado(estado)
  );

  escalonador_tx #(.TIMEOUT_CICLOS(50)) u_dut_to (
    .clock(clock), .reset(reset), .req0(b_req0), .req1(b_req1),
    .cmd0(b_cmd0), .dado0(b_dado0), .cmd1(b_cmd1), .dado1(b_dado1),
    .ack0(b_ack0), .ack1(b_ack1), .fim0(b_fim0), .fim1(b_fim1),
    .tx_inicia(b_tx_inicia), .tx_byte(b_tx_byte), .tx_ativo(b_tx_ativo),
    .tx_concluido(b_tx_concluido), .ocupado(b_ocupado),
    .erro_timeout(b_erro), .o_estado(b_estado)
  );

  // Transmitter model: takes a byte when idle and tx_inicia is high, stays busy
  // for 10 bit times, then raises tx_concluido for m_len cycles.
  assign tx_ativo     = m_busy;
  assign tx_concluido = (m_done != 0);

  always @(posedge clock) begin
    if (reset) begin
      m_busy <= 1'b0;
      m_done <= 0;
      m_cnt  <= 0;
    end else begin
      if (m_done != 0) m_done <= m_done - 1;
      if (!m_busy && tx_inicia) begin
        m_busy <= 1'b1;
        m_cnt  <= 10 * m_cpb;
        got_q.push_back(tx_byte);
      end else if (m_busy) begin
        if (m_cnt > 1) m_cnt <= m_cnt - 1;
        else begin
          m_busy <= 1'b0;
          m_done <= m_len;
        end
      end
    end
  end

  always @(posedge clock) begin
    if (fim0) fim0_cnt <= fim0_cnt + 1;
    if (fim1) fim1_cnt <= fim1_cnt + 1;
    if (b_fim0 || b_fim1) b_fim_cnt <= b_fim_cnt + 1;
  end

  task automatic wait_cycle;
    @(posedge clock);
    #1;
  endtask

  task automatic apply_reset;
    reset = 1'b1;
    req0 = 1'b0; req1 = 1'b0; b_req0 = 1'b0; b_req1 = 1'b0;
    repeat (2) wait_cycle;
    reset = 1'b0;
  endtask

  task automatic wait_ack(input int bound, output int waited);
    waited = 0;
    while (!(ack0 || ack1) && waited < bound) begin
      wait_cycle;
      waited++;
    end
  endtask

  task automatic wait_fim(input int bound, output int waited);
    waited = 0;
    while (!(fim0 || fim1) && waited < bound) begin
      wait_cycle;
      waited++;
    end
  endtask

  task automatic test_reset;
    apply_reset;
    n_chk++; if ({ack0, ack1, fim0, fim1} !== 4'b0000) begin n_err++; $display("FAIL reset_pulses: got %b required 0000", {ack0, ack1, fim0, fim1}); end
    n_chk++; if (tx_inicia !== 1'b0) begin n_err++; $display("FAIL reset_tx_inicia: got %b required 0", tx_inicia); end
    n_chk++; if (ocupado !== 1'b0) begin n_err++; $display("FAIL reset_ocupado: got %b required 0", ocupado); end
    n_chk++; if (erro_timeout !== 1'b0) begin n_err++; $display("FAIL reset_erro: got %b required 0", erro_timeout); end
    n_chk++; if (tx_byte !== 8'h00) begin n_err++; $display("FAIL reset_tx_byte: got %h required 00", tx_byte); end
    n_chk++; if (estado !== 3'd0) begin n_err++; $display("FAIL reset_estado: got %0d required 0", estado); end
  endtask

  task automatic test_basic;
    int w;
    logic [7:0] g, e;
    m_cpb = 87; m_len = 1;
    cmd0 = 8'h01; dado0 = 8'h2A;
    exp_q.push_back(8'h01); exp_q.push_back(8'h2A);
    req0 = 1'b1;
    wait_ack(10, w);
    n_chk++; if ({ack0, ack1} !== 2'b10) begin n_err++; $display("FAIL basic_ack: got %b required 10", {ack0, ack1}); end
    n_chk++; if (tx_inicia !== 1'b1 || tx_byte !== 8'h01) begin n_err++; $display("FAIL basic_first_tx: got inicia=%b byte=%h required 1/01", tx_inicia, tx_byte); end
    req0 = 1'b0; cmd0 = 8'hFF; dado0 = 8'hEE;
    wait_cycle;
    n_chk++; if (ack0 !== 1'b0) begin n_err++; $display("FAIL basic_ack_width: got %b required 0", ack0); end
    wait_fim(3000, w);
    n_chk++; if ({fim0, fim1} !== 2'b10) begin n_err++; $display("FAIL basic_fim: got %b required 10", {fim0, fim1}); end
    wait_cycle;
    n_chk++; if (fim0 !== 1'b0 || ocupado !== 1'b0) begin n_err++; $display("FAIL basic_after: got fim0=%b ocupado=%b required 0/0", fim0, ocupado); end
    n_chk++; if (got_q.size() != 2) begin n_err++; $display("FAIL basic_count: got %0d bytes required 2", got_q.size()); end
    while (got_q.size() > 0) begin
      g = got_q.pop_front(); e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
      n_chk++; if (g !== e) begin n_err++; $display("FAIL basic_byte: got %h required %h", g, e); end
    end
  endtask

  task automatic test_round_robin;
    int w;
    logic [1:0] exp_pat;
    logic [7:0] g, e;
    apply_reset;
    m_cpb = 4; m_len = 1;
    cmd0 = 8'hA0; dado0 = 8'hA1; cmd1 = 8'hB0; dado1 = 8'hB1;
    exp_q.push_back(8'hA0); exp_q.push_back(8'hA1);
    exp_q.push_back(8'hB0); exp_q.push_back(8'hB1);
    exp_q.push_back(8'hA0); exp_q.push_back(8'hA1);
    req0 = 1'b1; req1 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      exp_pat = (k % 2 == 0) ? 2'b10 : 2'b01;
      wait_ack(20, w);
      n_chk++; if ({ack0, ack1} !== exp_pat) begin n_err++; $display("FAIL rr_ack%0d: got %b required %b", k, {ack0, ack1}, exp_pat); end
      if (k > 0) begin
        n_chk++; if (w < 1) begin n_err++; $display("FAIL rr_gap%0d: got %0d cycles required >=1", k, w); end
      end
      if (k == 2) begin req0 = 1'b0; req1 = 1'b0; end
      wait_fim(300, w);
      n_chk++; if ({fim0, fim1} !== exp_pat) begin n_err++; $display("FAIL rr_fim%0d: got %b required %b", k, {fim0, fim1}, exp_pat); end
    end
    while (got_q.size() > 0) begin
      g = got_q.pop_front(); e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
      n_chk++; if (g !== e) begin n_err++; $display("FAIL rr_byte: got %h required %h", g, e); end
    end
  endtask

  task automatic test_double_done;
    int w;
    logic [7:0] g, e;
    m_cpb = 4; m_len = 2;
    cmd1 = 8'h5C; dado1 = 8'hC5;
    exp_q.push_back(8'h5C); exp_q.push_back(8'hC5);
    req1 = 1'b1;
    wait_ack(20, w);
    n_chk++; if ({ack0, ack1} !== 2'b01) begin n_err++; $display("FAIL dd_ack: got %b required 01", {ack0, ack1}); end
    req1 = 1'b0;
    wait_fim(300, w);
    n_chk++; if ({fim0, fim1} !== 2'b01) begin n_err++; $display("FAIL dd_fim: got %b required 01", {fim0, fim1}); end
    repeat (40) wait_cycle;
    n_chk++; if (got_q.size() != 2 || ocupado !== 1'b0) begin n_err++; $display("FAIL dd_count: got %0d bytes ocupado=%b required 2/0", got_q.size(), ocupado); end
    while (got_q.size() > 0) begin
      g = got_q.pop_front(); e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
      n_chk++; if (g !== e) begin n_err++; $display("FAIL dd_byte: got %h required %h", g, e); end
    end
    m_len = 1;
  endtask

  task automatic test_timeout;
    int n;
    int f0;
    b_tx_ativo = 1'b1; b_tx_concluido = 1'b0;
    b_cmd0 = 8'h77; b_dado0 = 8'h88;
    f0 = b_fim_cnt;
    b_req0 = 1'b1;
    n = 0;
    while (!b_ack0 && n < 10) begin wait_cycle; n++; end
    n_chk++; if (b_ack0 !== 1'b1 || b_tx_inicia !== 1'b1) begin n_err++; $display("FAIL to_grant: got ack0=%b inicia=%b required 1/1", b_ack0, b_tx_inicia); end
    b_req0 = 1'b0;
    n = 0;
    while (!b_erro && n < 200) begin wait_cycle; n++; end
    n_chk++; if (n != 50) begin n_err++; $display("FAIL to_cycles: got %0d required 50", n); end
    n_chk++; if (b_estado !== 3'd0 || b_ocupado !== 1'b0 || b_tx_inicia !== 1'b0) begin n_err++; $display("FAIL to_idle: got estado=%0d ocupado=%b inicia=%b required 0/0/0", b_estado, b_ocupado, b_tx_inicia); end
    repeat (20) wait_cycle;
    n_chk++; if (b_erro !== 1'b1) begin n_err++; $display("FAIL to_sticky: got %b required 1", b_erro); end
    n_chk++; if (b_fim_cnt != f0) begin n_err++; $display("FAIL to_no_fim: got %0d pulses required 0", b_fim_cnt - f0); end
  endtask

  task automatic test_reset_mid;
    int w;
    int f0, f1;
    logic [7:0] g, e;
    m_cpb = 8; m_len = 1;
    cmd0 = 8'h11; dado0 = 8'h22;
    exp_q.push_back(8'h11); exp_q.push_back(8'h22);
    f0 = fim0_cnt; f1 = fim1_cnt;
    req0 = 1'b1;
    wait_ack(20, w);
    req0 = 1'b0;
    w = 0;
    while (estado !== 3'd4 && w < 300) begin wait_cycle; w++; end
    n_chk++; if (estado !== 3'd4) begin n_err++; $display("FAIL rm_reach: got estado=%0d required 4", estado); end
    reset = 1'b1;
    wait_cycle;
    reset = 1'b0;
    n_chk++; if ({ack0, ack1, fim0, fim1, tx_inicia, ocupado, erro_timeout} !== 7'b0) begin n_err++; $display("FAIL rm_outputs: got %b required 0000000", {ack0, ack1, fim0, fim1, tx_inicia, ocupado, erro_timeout}); end
    n_chk++; if (tx_byte !== 8'h00 || estado !== 3'd0) begin n_err++; $display("FAIL rm_state: got byte=%h estado=%0d required 00/0", tx_byte, estado); end
    n_chk++; if (b_erro !== 1'b0) begin n_err++; $display("FAIL rm_erro_clear: got %b required 0", b_erro); end
    cmd1 = 8'h33; dado1 = 8'h44;
    exp_q.push_back(8'h33); exp_q.push_back(8'h44);
    req1 = 1'b1;
    wait_ack(20, w);
    n_chk++; if ({ack0, ack1} !== 2'b01) begin n_err++; $display("FAIL rm_ack: got %b required 01", {ack0, ack1}); end
    req1 = 1'b0;
    wait_fim(400, w);
    n_chk++; if ({fim0, fim1} !== 2'b01) begin n_err++; $display("FAIL rm_fim: got %b required 01", {fim0, fim1}); end
    wait_cycle;
    n_chk++; if (fim0_cnt != f0 || fim1_cnt != f1 + 1) begin n_err++; $display("FAIL rm_fim_count: got %0d/%0d required %0d/%0d", fim0_cnt, fim1_cnt, f0, f1 + 1); end
    while (got_q.size() > 0) begin
      g = got_q.pop_front(); e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
      n_chk++; if (g !== e) begin n_err++; $display("FAIL rm_byte: got %h required %h", g, e); end
    end
  endtask

  initial begin
    reset = 1'b1;
    req0 = 1'b0; req1 = 1'b0;
    cmd0 = 8'h00; dado0 = 8'h00; cmd1 = 8'h00; dado1 = 8'h00;
    b_req0 = 1'b0; b_req1 = 1'b0;
    b_cmd0 = 8'h00; b_dado0 = 8'h00; b_cmd1 = 8'h00; b_dado1 = 8'h00;
    b_tx_ativo = 1'b0; b_tx_concluido = 1'b0;
    test_reset;
    test_basic;
    test_round_robin;
    test_double_done;
    test_timeout;
    test_reset_mid;
    n_chk++; if (exp_q.size() != 0 || got_q.size() != 0) begin n_err++; $display("FAIL sb_drain: got exp=%0d got=%0d left required 0/0", exp_q.size(), got_q.size()); end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
